pixel_write_arbiter: RTL and testbench
======================================

PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 SHALL have parameter N_ENG, default 5, number of drawing engines sharing the framebuffer write port.
REQ-002 SHALL have parameter ADDR_W, default 19, framebuffer word address width.
REQ-003 SHALL have parameter PIX_W, default 12, pixel width (R[11:8], G[7:4], B[3:0]).
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum consecutive transfers granted to one engine; legal range 1..255.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 rst_  input  1  reset, asynchronous, active-high.
REQ-007 eng_rts  input  N_ENG  per-engine ready-to-send.
REQ-008 eng_addr  input  N_ENG*ADDR_W  packed addresses, engine i at [i*ADDR_W +: ADDR_W].
REQ-009 eng_pixel  input  N_ENG*PIX_W  packed pixels, engine i at [i*PIX_W +: PIX_W].
REQ-010 eng_rtr  output  N_ENG  per-engine ready-to-receive, at most one bit set.
REQ-011 mem_rts  output  1  framebuffer write valid.
REQ-012 mem_addr  output  ADDR_W  framebuffer write address.
REQ-013 mem_pixel  output  PIX_W  framebuffer write data.
REQ-014 mem_rtr  input  1  framebuffer accepts write this cycle.
REQ-015 owner  output  3  index of current owner; meaningful only while busy=1.
REQ-016 busy  output  1  arbiter in LOCKED state.

Function
REQ-017 Transfer on engine side: eng_rts[i] & eng_rtr[i] in same cycle; on memory side: mem_rts & mem_rtr.
REQ-018 Output stage: single register (valid, addr, pixel); "can_accept" = !valid | mem_rtr.
REQ-019 eng_rtr[i] = can_accept & state==LOCKED & owner==i (combinational from registers and mem_rtr only, not from eng_rts).
REQ-020 Accepted engine word SHALL appear on mem_addr/mem_pixel with mem_rts=1 the following cycle (latency 1).
REQ-021 mem_rts/mem_addr/mem_pixel SHALL hold stable while mem_rts=1 & mem_rtr=0.
REQ-022 Simultaneous drain and accept: register loads new word, mem_rts stays 1, no bubble; sustained throughput 1 word/cycle.
REQ-023 States: IDLE, LOCKED.
REQ-024 IDLE: if any eng_rts set, select first requester searching from (last_owner+1) mod N_ENG upward with wrap; set owner, burst_cnt=0, go LOCKED next cycle; eng_rtr all 0 in IDLE.
REQ-025 LOCKED: burst_cnt increments on each engine-side transfer.
REQ-026 LOCKED -> IDLE when owner's eng_rts=0 in a cycle where eng_rtr[owner]=1, or when a transfer makes burst_cnt reach MAX_BURST; last_owner<=owner on exit.
REQ-027 Owner dropping eng_rts while eng_rtr=0 (memory stalled) SHALL NOT release the lock.
REQ-028 Re-arbitration costs exactly one IDLE cycle; a sole requester hitting MAX_BURST is re-granted after that cycle.
REQ-029 Engine index >= N_ENG never granted; requests from non-owners ignored until next IDLE.
REQ-030 Round-robin SHALL guarantee every continuously requesting engine a grant within N_ENG arbitration rounds.

Reset
REQ-031 While rst_=1: state=IDLE, eng_rtr=0, mem_rts=0, mem_addr=0, mem_pixel=0, owner=0, busy=0, burst_cnt=0, last_owner=N_ENG-1 (so engine 0 wins first).
REQ-032 Reset asserted mid-burst SHALL drop any registered, unaccepted word; no write emitted after reset release until a new engine transfer.
REQ-033 Deassertion takes effect on the next rising edge; first grant possible in the cycle after IDLE sees eng_rts.

Verification
REQ-034 Single requester: eng_rts=5'b00010, addr 0x00040, pixel 0xF00, mem_rtr=1 -> owner=1, eng_rtr=5'b00010, mem_rts=1 with addr 0x00040 pixel 0xF00 one cycle after transfer.
REQ-035 Burst limit: engine 1 requests 40 words, MAX_BURST=16, mem_rtr=1 -> runs of 16 transfers separated by one IDLE cycle; 40 words out in order, none lost or duplicated.
REQ-036 Fairness: all five eng_rts held high, MAX_BURST=4 -> grant order 0,1,2,3,4,0...; each burst exactly 4 words.
REQ-037 Backpressure: mem_rtr low for 10 cycles mid-burst -> mem_addr/mem_pixel stable, eng_rtr=0 during stall, owner's eng_rts drop during stall does not release lock; resume with no loss.
REQ-038 Reset mid-burst: rst_ pulsed while mem_rts=1, mem_rtr=0 -> all outputs at reset values immediately (asynchronous), pending word never written.
REQ-039 Simultaneous drain/accept: mem_rtr=1, owner eng_rts=1 continuous -> mem_rts high every cycle of burst, one word per cycle.

Source files
------------

// File: rtl/pixel_write_arbiter.sv
// pixel_write_arbiter
// Shares one framebuffer write port among N_ENG drawing engines. An engine
// is granted the port in round-robin order and keeps it for up to MAX_BURST
// transfers, or until it stops requesting. Accepted words go through a
// single output register, so they reach memory one cycle after the engine
// transfer, and the port sustains one word per cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst_       asynchronous active-high reset
//   eng_rts    per-engine ready-to-send
//   eng_addr   packed engine addresses, engine i at [i*ADDR_W +: ADDR_W]
//   eng_pixel  packed engine pixels, engine i at [i*PIX_W +: PIX_W]
//   eng_rtr    per-engine ready-to-receive (one-hot or zero)
//   mem_rts    framebuffer write valid
//   mem_addr   framebuffer write address
//   mem_pixel  framebuffer write data
//   mem_rtr    framebuffer accepts the write this cycle
//   owner      engine currently holding the port (valid while busy)
//   busy       arbiter is locked to an owner
module pixel_write_arbiter #(
  parameter int N_ENG     = 5,
  parameter int ADDR_W    = 19,
  parameter int PIX_W     = 12,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [N_ENG-1:0]        eng_rts,
  input  logic [N_ENG*ADDR_W-1:0] eng_addr,
  input  logic [N_ENG*PIX_W-1:0]  eng_pixel,
  output logic [N_ENG-1:0]        eng_rtr,
  output logic                    mem_rts,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [PIX_W-1:0]        mem_pixel,
  input  logic                    mem_rtr,
  output logic [2:0]              owner,
  output logic                    busy
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [2:0] LAST_ENG_C  = 3'(N_ENG - 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t              r_state;
  logic [2:0]          r_owner;
  logic [2:0]          r_lastOwner;
  logic [7:0]          r_burstCnt;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_addr;
  logic [PIX_W-1:0]    r_pixel;

  state_t              w_stateNext;
  logic [2:0]          w_ownerNext;
  logic [2:0]          w_lastOwnerNext;
  logic [7:0]          w_burstNext;
  logic [7:0]          w_burstInc;
  logic                w_validNext;
  logic [ADDR_W-1:0]   w_addrNext;
  logic [PIX_W-1:0]    w_pixelNext;

  logic                w_canAccept;
  logic                w_locked;
  logic                w_ownerRts;
  logic [ADDR_W-1:0]   w_ownerAddr;
  logic [PIX_W-1:0]    w_ownerPixel;
  logic                w_xfer;
  logic                w_grantFound;
  logic [2:0]          w_grantIdx;
  int                  w_dist;
  int                  w_bestDist;

  // The output register can take a new word when it is empty or when its
  // current word is leaving this cycle.
  assign w_canAccept = !r_valid || mem_rtr;
  assign w_locked    = (r_state == LOCKED);
  assign w_xfer      = w_canAccept && w_locked && w_ownerRts;
  assign w_burstInc  = r_burstCnt + 8'd1;

  // Pick out the owner's request and data word.
  always_comb begin
    w_ownerRts   = 1'b0;
    w_ownerAddr  = '0;
    w_ownerPixel = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (r_owner == 3'(i)) begin
        w_ownerRts   = eng_rts[i];
        w_ownerAddr  = eng_addr[i*ADDR_W +: ADDR_W];
        w_ownerPixel = eng_pixel[i*PIX_W +: PIX_W];
      end
    end
  end

  // Round-robin search: each requester is ranked by its distance after
  // the previous owner, and the closest one wins. Ranking by distance
  // avoids indexing the request vector with a runtime value.
  always_comb begin
    w_grantFound = 1'b0;
    w_grantIdx   = '0;
    w_bestDist   = N_ENG;
    w_dist       = 0;
    for (int i = 0; i < N_ENG; i++) begin
      w_dist = (i + N_ENG - 1 - int'(r_lastOwner)) % N_ENG;
      if (eng_rts[i] && (w_dist < w_bestDist)) begin
        w_bestDist   = w_dist;
        w_grantFound = 1'b1;
        w_grantIdx   = 3'(i);
      end
    end
  end

  // Ready-to-receive depends only on registered state and mem_rtr, never
  // on eng_rts, so engines can wait for it before they raise rts.
  always_comb begin
    eng_rtr = '0;
    for (int i = 0; i < N_ENG; i++) begin
      eng_rtr[i] = w_canAccept && w_locked && (r_owner == 3'(i));
    end
  end

  // Next-state logic. A locked owner is released only in a cycle where it
  // is being offered a slot, so a request dropped during a memory stall
  // does not end the burst.
  always_comb begin
    w_stateNext     = r_state;
    w_ownerNext     = r_owner;
    w_lastOwnerNext = r_lastOwner;
    w_burstNext     = r_burstCnt;
    case (r_state)
      IDLE: begin
        if (w_grantFound) begin
          w_stateNext = LOCKED;
          w_ownerNext = w_grantIdx;
          w_burstNext = '0;
        end
      end
      LOCKED: begin
        if (w_canAccept) begin
          if (!w_ownerRts) begin
            w_stateNext     = IDLE;
            w_lastOwnerNext = r_owner;
          end else begin
            w_burstNext = w_burstInc;
            if (w_burstInc == MAX_BURST_C) begin
              w_stateNext     = IDLE;
              w_lastOwnerNext = r_owner;
            end
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Output stage: load on an engine transfer, which also covers the case
  // of draining and refilling in the same cycle; otherwise empty it when
  // memory takes the word. Address and pixel hold while stalled.
  always_comb begin
    w_validNext = r_valid;
    w_addrNext  = r_addr;
    w_pixelNext = r_pixel;
    if (w_xfer) begin
      w_validNext = 1'b1;
      w_addrNext  = w_ownerAddr;
      w_pixelNext = w_ownerPixel;
    end else if (mem_rtr) begin
      w_validNext = 1'b0;
    end
  end

  // State register. Reset discards any pending word, and the previous
  // owner is preset to the last engine so engine 0 wins first.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_lastOwner <= LAST_ENG_C;
      r_burstCnt  <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_pixel     <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_owner     <= w_ownerNext;
      r_lastOwner <= w_lastOwnerNext;
      r_burstCnt  <= w_burstNext;
      r_valid     <= w_validNext;
      r_addr      <= w_addrNext;
      r_pixel     <= w_pixelNext;
    end
  end

  assign mem_rts   = r_valid;
  assign mem_addr  = r_addr;
  assign mem_pixel = r_pixel;
  assign owner     = r_owner;
  assign busy      = w_locked;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb_pixel_write_arbiter
// Directed bench for pixel_write_arbiter. Two instances share the stimulus:
// dutA uses MAX_BURST=16 and dutB uses MAX_BURST=4 for the fairness run.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
module tb_pixel_write_arbiter;

  localparam int N_ENG  = 5;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 12;

  logic                    clk = 1'b0;
  logic                    rst_;
  logic [N_ENG-1:0]        eng_rts;
  logic [N_ENG*ADDR_W-1:0] eng_addr;
  logic [N_ENG*PIX_W-1:0]  eng_pixel;
  logic                    mem_rtr;

  logic [N_ENG-1:0]  rtrA, rtrB;
  logic              memRtsA, memRtsB;
  logic [ADDR_W-1:0] memAddrA, memAddrB;
  logic [PIX_W-1:0]  memPixelA, memPixelB;
  logic [2:0]        ownerA, ownerB;
  logic              busyA, busyB;

  int assertCount = 0;
  int failCount   = 0;

  logic [ADDR_W-1:0] baseAddr;
  logic [PIX_W-1:0]  basePix;
  int                k;
  int                outIdx;
  logic              xfer;

  pixel_write_arbiter #(.N_ENG(N_ENG), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MAX_BURST(16)) dutA (
    .clk(clk), .rst_(rst_), .eng_rts(eng_rts), .eng_addr(eng_addr), .eng_pixel(eng_pixel),
    .eng_rtr(rtrA), .mem_rts(memRtsA), .mem_addr(memAddrA), .mem_pixel(memPixelA),
    .mem_rtr(mem_rtr), .owner(ownerA), .busy(busyA)
  );

  pixel_write_arbiter #(.N_ENG(N_ENG), .ADDR_W(ADDR_W), .PIX_W(PIX_W), .MAX_BURST(4)) dutB (
    .clk(clk), .rst_(rst_), .eng_rts(eng_rts), .eng_addr(eng_addr), .eng_pixel(eng_pixel),
    .eng_rtr(rtrB), .mem_rts(memRtsB), .mem_addr(memAddrB), .mem_pixel(memPixelB),
    .mem_rtr(mem_rtr), .owner(ownerB), .busy(busyB)
  );

  always #5 clk = ~clk;

  // Single checking point for every comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one active engine with word kk of its stream; others idle.
  task automatic applyStimulus(input logic [N_ENG-1:0] rts, input logic memRtr, input int idx, input int kk);
    eng_rts   = rts;
    mem_rtr   = memRtr;
    eng_addr  = '0;
    eng_pixel = '0;
    eng_addr[idx*ADDR_W +: ADDR_W] = baseAddr + ADDR_W'(kk);
    eng_pixel[idx*PIX_W +: PIX_W]  = basePix + PIX_W'(kk);
  endtask

  // Every engine requests, each with its own address region.
  task automatic applyAll();
    eng_rts = '1;
    mem_rtr = 1'b1;
    for (int i = 0; i < N_ENG; i++) begin
      eng_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i * 32'h10000);
      eng_pixel[i*PIX_W +: PIX_W]  = PIX_W'(i);
    end
  endtask

  // Reset through one rising edge, then release; caller is in cycle 0.
  task automatic doReset();
    rst_      = 1'b1;
    eng_rts   = '0;
    mem_rtr   = 1'b0;
    eng_addr  = '0;
    eng_pixel = '0;
    tick();
    rst_ = 1'b0;
  endtask

  // In-order check of words accepted by memory on dutA.
  task automatic checkMemA(input string tag);
    if (memRtsA && mem_rtr) begin
      checkOutput({tag, "Addr"}, 32'(memAddrA), 32'(baseAddr + ADDR_W'(outIdx)));
      checkOutput({tag, "Pix"}, 32'(memPixelA), 32'(basePix + PIX_W'(outIdx)));
      outIdx++;
    end
  endtask

  function automatic logic inBurstRun(input int c);
    return (c >= 1 && c <= 16) || (c >= 18 && c <= 33) || (c >= 35 && c <= 42);
  endfunction

  initial begin
    logic [N_ENG-1:0] expRtr;
    logic             expBusy;
    logic             expMem;
    logic             memRtr;
    logic [N_ENG-1:0] rts;
    int               phase;
    int               own;

    rst_      = 1'b0;
    eng_rts   = '0;
    mem_rtr   = 1'b0;
    eng_addr  = '0;
    eng_pixel = '0;
    baseAddr  = '0;
    basePix   = '0;
    k         = 0;
    outIdx    = 0;
    #1 rst_ = 1'b1;
    tick();

    // Reset values.
    checkOutput("rstRtr", 32'(rtrA), 32'd0);
    checkOutput("rstMemRts", 32'(memRtsA), 32'd0);
    checkOutput("rstMemAddr", 32'(memAddrA), 32'd0);
    checkOutput("rstMemPix", 32'(memPixelA), 32'd0);
    checkOutput("rstOwner", 32'(ownerA), 32'd0);
    checkOutput("rstBusy", 32'(busyA), 32'd0);
    checkOutput("rstRtrB", 32'(rtrB), 32'd0);

    // Single requester, engine 1.
    $display("[TB] single requester");
    doReset();
    baseAddr = 19'h00040;
    basePix  = 12'hF00;
    applyStimulus(5'b00010, 1'b1, 1, 0);
    @(negedge clk);
    checkOutput("singleIdleBusy", 32'(busyA), 32'd0);
    checkOutput("singleIdleRtr", 32'(rtrA), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("singleOwner", 32'(ownerA), 32'd1);
    checkOutput("singleBusy", 32'(busyA), 32'd1);
    checkOutput("singleRtr", 32'(rtrA), 32'b00010);
    checkOutput("singleMemRts0", 32'(memRtsA), 32'd0);
    tick();
    applyStimulus(5'b00000, 1'b1, 1, 0);
    @(negedge clk);
    checkOutput("singleMemRts1", 32'(memRtsA), 32'd1);
    checkOutput("singleMemAddr", 32'(memAddrA), 32'h00040);
    checkOutput("singleMemPix", 32'(memPixelA), 32'hF00);
    checkOutput("singleRtrDrop", 32'(rtrA), 32'b00010);
    tick();
    @(negedge clk);
    checkOutput("singleRelBusy", 32'(busyA), 32'd0);
    checkOutput("singleRelMemRts", 32'(memRtsA), 32'd0);

    // Engine 1 sends 40 words with MAX_BURST=16: runs of 16/16/8 with one
    // idle cycle between runs, and memory valid on every cycle after a run cycle.
    $display("[TB] burst limit");
    doReset();
    baseAddr = 19'h01000;
    basePix  = 12'h100;
    k        = 0;
    outIdx   = 0;
    for (int cyc = 0; cyc < 46; cyc++) begin
      applyStimulus((k < 40) ? 5'b00010 : 5'b00000, 1'b1, 1, k);
      @(negedge clk);
      expRtr = (inBurstRun(cyc) || cyc == 43) ? 5'b00010 : 5'b00000;
      checkOutput("burstRtr", 32'(rtrA), 32'(expRtr));
      checkOutput("burstMemRts", 32'(memRtsA), 32'(inBurstRun(cyc - 1)));
      checkMemA("burstMem");
      xfer = rtrA[1] & eng_rts[1];
      tick();
      if (xfer) k++;
    end
    checkOutput("burstWordsIn", 32'(k), 32'd40);
    checkOutput("burstWordsOut", 32'(outIdx), 32'd40);

    // Fairness on dutB: everyone requests, grants rotate 0..4 in bursts of 4.
    $display("[TB] fairness");
    doReset();
    for (int cyc = 0; cyc < 51; cyc++) begin
      applyAll();
      @(negedge clk);
      expRtr  = '0;
      expBusy = 1'b0;
      if (cyc > 0) begin
        phase = (cyc - 1) % 5;
        if (phase != 4) begin
          own     = ((cyc - 1) / 5) % 5;
          expRtr  = 5'(1 << own);
          expBusy = 1'b1;
          checkOutput("fairOwner", 32'(ownerB), 32'(own));
        end
      end
      checkOutput("fairRtr", 32'(rtrB), 32'(expRtr));
      checkOutput("fairBusy", 32'(busyB), 32'(expBusy));
      expMem = (cyc >= 2) && (((cyc - 2) % 5) != 4);
      checkOutput("fairMemRts", 32'(memRtsB), 32'(expMem));
      if (expMem) begin
        checkOutput("fairMemAddr", 32'(memAddrB), 32'((((cyc - 2) / 5) % 5) * 32'h10000));
      end
      tick();
    end

    // Backpressure: memory stalls for 10 cycles while word 2 is pending,
    // and engine 2 drops its request for part of the stall.
    $display("[TB] backpressure");
    doReset();
    baseAddr = 19'h02000;
    basePix  = 12'h200;
    k        = 0;
    outIdx   = 0;
    for (int cyc = 0; cyc < 31; cyc++) begin
      memRtr = !(cyc >= 4 && cyc <= 13);
      rts    = ((k < 8) && !(cyc >= 8 && cyc <= 13)) ? 5'b00100 : 5'b00000;
      applyStimulus(rts, memRtr, 2, k);
      @(negedge clk);
      if (!memRtr) begin
        checkOutput("stallMemRts", 32'(memRtsA), 32'd1);
        checkOutput("stallMemAddr", 32'(memAddrA), 32'h02002);
        checkOutput("stallMemPix", 32'(memPixelA), 32'h202);
        checkOutput("stallRtr", 32'(rtrA), 32'd0);
        checkOutput("stallBusy", 32'(busyA), 32'd1);
        checkOutput("stallOwner", 32'(ownerA), 32'd2);
      end
      if (cyc == 14) begin
        checkOutput("resumeRtr", 32'(rtrA), 32'b00100);
      end
      checkMemA("bpMem");
      xfer = rtrA[2] & eng_rts[2];
      tick();
      if (xfer) k++;
    end
    checkOutput("bpWordsIn", 32'(k), 32'd8);
    checkOutput("bpWordsOut", 32'(outIdx), 32'd8);
    checkOutput("bpEndBusy", 32'(busyA), 32'd0);

    // Reset pulsed while a word is stalled at the memory port.
    $display("[TB] reset mid-burst");
    doReset();
    baseAddr = 19'h03000;
    basePix  = 12'h300;
    k        = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      applyStimulus(5'b01000, (cyc < 4), 3, k);
      @(negedge clk);
      xfer = rtrA[3] & eng_rts[3];
      tick();
      if (xfer) k++;
    end
    @(negedge clk);
    checkOutput("preRstMemRts", 32'(memRtsA), 32'd1);
    checkOutput("preRstMemAddr", 32'(memAddrA), 32'h03002);
    #2 rst_ = 1'b1;
    #1;
    checkOutput("asyncRstMemRts", 32'(memRtsA), 32'd0);
    checkOutput("asyncRstMemAddr", 32'(memAddrA), 32'd0);
    checkOutput("asyncRstMemPix", 32'(memPixelA), 32'd0);
    checkOutput("asyncRstRtr", 32'(rtrA), 32'd0);
    checkOutput("asyncRstOwner", 32'(ownerA), 32'd0);
    checkOutput("asyncRstBusy", 32'(busyA), 32'd0);
    tick();
    rst_ = 1'b0;
    applyStimulus(5'b00000, 1'b1, 3, k);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checkOutput("postRstMemRts", 32'(memRtsA), 32'd0);
      checkOutput("postRstBusy", 32'(busyA), 32'd0);
      tick();
    end
    // Engines 0 and 4 compete: engine 0 must win right after reset.
    baseAddr = 19'h04000;
    basePix  = 12'h400;
    applyStimulus(5'b10001, 1'b1, 0, 0);
    @(negedge clk);
    checkOutput("firstGrantIdle", 32'(busyA), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("firstGrantBusy", 32'(busyA), 32'd1);
    checkOutput("firstGrantOwner", 32'(ownerA), 32'd0);
    checkOutput("firstGrantRtr", 32'(rtrA), 32'b00001);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
